// File: rtl/esc_mux_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | esc_mux_pkg                                                          |
// | Shared types and constants for the DSHOT / ESC-passthrough pad       |
// | sequencer.                                                           |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package esc_mux_pkg;

  // Status readback encodings are visible to software, so they are pinned.
  typedef enum logic [2:0] {
    ST_DSHOT     = 3'd0,
    ST_DRAIN     = 3'd1,
    ST_GUARD_IN  = 3'd2,
    ST_SERIAL    = 3'd3,
    ST_GUARD_OUT = 3'd4
  } seq_state_t;

  localparam logic MUX_SEL_DSHOT  = 1'b1;
  localparam logic MUX_SEL_SERIAL = 1'b0;

  localparam int TIMER_W = 16;

endpackage
`default_nettype wire

// File: rtl/esc_seq_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | esc_seq_timer                                                        |
// | Loadable down-counter with a terminal flag. Shared by the drain      |
// | timeout and the pad guard windows, which never overlap.              |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module esc_seq_timer
  import esc_mux_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  input  logic               en,
  output logic               done
);

  logic [TIMER_W-1:0] count;

  // Load wins over counting; the counter parks at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule
`default_nettype wire

// File: rtl/esc_passthrough_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | esc_passthrough_sequencer                                            |
// | Moves the shared motor pads between DSHOT and ESC serial passthrough |
// | with frame drain, tristate guard windows and an idle watchdog.       |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module esc_passthrough_sequencer
  import esc_mux_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ    = 72_000_000,
  parameter int unsigned GUARD_CYCLES   = 72,
  parameter int unsigned DRAIN_MAX      = 7200,
  parameter int unsigned IDLE_TIMEOUT_S = 5
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_ni,
  input  logic       cpu_req_i,
  input  logic       auto_req_i,
  input  logic [1:0] cfg_ch_i,
  input  logic       activity_i,
  input  logic       dshot_busy_i,
  output logic       dshot_hold_o,
  output logic       mux_sel_o,
  output logic [1:0] mux_ch_o,
  output logic       pad_tristate_o,
  output logic       serial_en_o,
  output logic       timeout_o,
  output logic [2:0] state_o
);

  localparam logic [31:0]        IDLE_LIMIT = CLK_FREQ_HZ * IDLE_TIMEOUT_S;
  // A window of N cycles needs N-1 loaded: the terminal check uses the
  // cycle after the load.
  localparam logic [TIMER_W-1:0] GUARD_LOAD = TIMER_W'(GUARD_CYCLES - 1);
  localparam logic [TIMER_W-1:0] DRAIN_LOAD = TIMER_W'(DRAIN_MAX - 1);

  seq_state_t         state;
  logic               auto_active;
  logic               lockout;
  logic [31:0]        watchdog;
  logic               req;
  logic               kick;
  logic               expire;
  logic               tmr_load;
  logic [TIMER_W-1:0] tmr_val;
  logic               tmr_en;
  logic               tmr_done;

  assign req    = (cpu_req_i & ~lockout) | auto_req_i | auto_active;
  assign kick   = activity_i | auto_req_i;
  // Activity in the expiry cycle rescues the session.
  assign expire = (watchdog == IDLE_LIMIT) && !kick;

  esc_seq_timer u_timer (
    .clk      (wb_clk_i),
    .rst_n    (wb_rst_ni),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .done     (tmr_done)
  );

  // Timer control: reload on every transition into a timed state.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = GUARD_LOAD;
    tmr_en   = 1'b0;
    case (state)
      ST_DSHOT: begin
        if (req) begin
          tmr_load = 1'b1;
          tmr_val  = DRAIN_LOAD;
        end
      end
      ST_DRAIN: begin
        if (!req || !dshot_busy_i || tmr_done) tmr_load = 1'b1;
        else                                   tmr_en   = 1'b1;
      end
      ST_GUARD_IN, ST_GUARD_OUT: tmr_en = 1'b1;
      ST_SERIAL: begin
        if (expire || !req || (cfg_ch_i != mux_ch_o)) tmr_load = 1'b1;
      end
      default: tmr_load = 1'b1;
    endcase
  end

  // Sequencer FSM with registered pad controls.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state          <= ST_DSHOT;
      mux_sel_o      <= MUX_SEL_DSHOT;
      mux_ch_o       <= 2'd0;
      dshot_hold_o   <= 1'b0;
      pad_tristate_o <= 1'b0;
      serial_en_o    <= 1'b0;
      timeout_o      <= 1'b0;
      auto_active    <= 1'b0;
      lockout        <= 1'b0;
      watchdog       <= 32'd0;
    end else begin
      timeout_o <= 1'b0;
      if (!cpu_req_i) lockout <= 1'b0;
      case (state)
        ST_DSHOT: begin
          if (req) begin
            mux_ch_o     <= cfg_ch_i;
            dshot_hold_o <= 1'b1;
            if (auto_req_i) auto_active <= 1'b1;
            state        <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!req) begin
            // Abort before the pads were ever handed over.
            pad_tristate_o <= 1'b1;
            state          <= ST_GUARD_OUT;
          end else if (!dshot_busy_i || tmr_done) begin
            mux_sel_o      <= MUX_SEL_SERIAL;
            pad_tristate_o <= 1'b1;
            state          <= ST_GUARD_IN;
          end
        end
        ST_GUARD_IN: begin
          if (tmr_done) begin
            pad_tristate_o <= 1'b0;
            serial_en_o    <= 1'b1;
            watchdog       <= 32'd0;
            state          <= ST_SERIAL;
          end
        end
        ST_SERIAL: begin
          if (expire || !req) begin
            if (expire) begin
              timeout_o   <= 1'b1;
              auto_active <= 1'b0;
              // A held CPU request must be released before it counts again.
              lockout     <= cpu_req_i;
            end
            serial_en_o    <= 1'b0;
            pad_tristate_o <= 1'b1;
            mux_sel_o      <= MUX_SEL_DSHOT;
            state          <= ST_GUARD_OUT;
          end else if (cfg_ch_i != mux_ch_o) begin
            serial_en_o    <= 1'b0;
            pad_tristate_o <= 1'b1;
            mux_ch_o       <= cfg_ch_i;
            state          <= ST_GUARD_IN;
          end else if (kick) begin
            watchdog <= 32'd0;
          end else begin
            watchdog <= watchdog + 32'd1;
          end
        end
        ST_GUARD_OUT: begin
          if (tmr_done) begin
            pad_tristate_o <= 1'b0;
            dshot_hold_o   <= 1'b0;
            state          <= ST_DSHOT;
          end
        end
        default: begin
          serial_en_o    <= 1'b0;
          pad_tristate_o <= 1'b1;
          mux_sel_o      <= MUX_SEL_DSHOT;
          dshot_hold_o   <= 1'b1;
          state          <= ST_GUARD_OUT;
        end
      endcase
    end
  end

  assign state_o = state;

endmodule
`default_nettype wire
